// File: rtl/i2c_pad_conditioner.sv
// I2C pad front end: per-line synchroniser + glitch filter, START/STOP
// detection, bus-busy tracking, clock-stretch and arbitration-loss monitor.

// Per-line conditioning: SYNC_STAGES flop synchroniser followed by a
// FILTER_LEN-sample persistence filter. Output idles high like the bus.
module i2c_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic pad_raw,
   output logic filt
);
   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain, shifts the raw pad level towards s.
   always_ff @(posedge clk) begin
      if (!reset) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pad_raw};
   end

   // Accept a new level only after FILTER_LEN consecutive differing samples;
   // any sample matching the current level restarts the count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         filt <= 1'b1;
         cnt  <= '0;
      end else if (s == filt) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         filt <= s;
         cnt  <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

module i2c_pad_conditioner #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 3,
   parameter int BUSFREE_CYCLES = 500
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_pad_raw,
   input  logic sda_pad_raw,
   input  logic scl_padoen,
   input  logic sda_padoen,
   input  logic arb_check,
   input  logic arb_clr,
   output logic scl_i,
   output logic sda_i,
   output logic start_det,
   output logic stop_det,
   output logic bus_busy,
   output logic scl_stretch,
   output logic arb_lost
);
   localparam int NUM_LINES = 2;
   localparam int LINE_SCL  = 0;
   localparam int LINE_SDA  = 1;
   localparam int FREE_W    = $clog2(BUSFREE_CYCLES + 1);
   localparam logic [FREE_W-1:0] FREE_LAST = FREE_W'(BUSFREE_CYCLES - 1);

   typedef enum logic {S_IDLE, S_BUSY} bus_state_t;

   logic [NUM_LINES-1:0] pad_raw;
   logic [NUM_LINES-1:0] filt;
   logic                 scl_q, sda_q;
   logic                 start_c, stop_c, scl_rise, arb_set;
   logic [FREE_W-1:0]    free_cnt;
   bus_state_t           state;

   assign pad_raw[LINE_SCL] = scl_pad_raw;
   assign pad_raw[LINE_SDA] = sda_pad_raw;

   // One identical conditioner per bus line.
   for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
      i2c_line_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN)
      ) u_line (
         .clk     (clk),
         .reset   (reset),
         .pad_raw (pad_raw[i]),
         .filt    (filt[i])
      );
   end

   assign scl_i = filt[LINE_SCL];
   assign sda_i = filt[LINE_SDA];

   // SDA edges only count while SCL is steady high, so a simultaneous
   // SCL/SDA change is never taken as START or STOP.
   assign start_c  =  sda_q & ~sda_i & scl_q & scl_i;
   assign stop_c   = ~sda_q &  sda_i & scl_q & scl_i;
   assign scl_rise = ~scl_q &  scl_i;
   assign arb_set  = scl_rise & arb_check & sda_padoen & ~sda_i & bus_busy;

   // Previous filtered levels and registered START/STOP pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         scl_q     <= 1'b1;
         sda_q     <= 1'b1;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         scl_q     <= scl_i;
         sda_q     <= sda_i;
         start_det <= start_c;
         stop_det  <= stop_c;
      end
   end

   // Bus ownership FSM; the free counter recovers from a lost STOP.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         bus_busy <= 1'b0;
         free_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               free_cnt <= '0;
               if (start_c) begin
                  state    <= S_BUSY;
                  bus_busy <= 1'b1;
               end
            end
            S_BUSY: begin
               if (stop_c || free_cnt == FREE_LAST) begin
                  state    <= S_IDLE;
                  bus_busy <= 1'b0;
                  free_cnt <= '0;
               end else if (scl_i && sda_i) begin
                  if (free_cnt != FREE_LAST) free_cnt <= free_cnt + 1'b1;
               end else begin
                  free_cnt <= '0;
               end
            end
            default: begin
               state    <= S_IDLE;
               bus_busy <= 1'b0;
               free_cnt <= '0;
            end
         endcase
      end
   end

   // Stretch: the core let SCL go but the line is still low.
   always_ff @(posedge clk) begin
      if (!reset) scl_stretch <= 1'b0;
      else        scl_stretch <= scl_padoen & ~scl_i;
   end

   // Sticky arbitration-lost flag; a set in the clearing cycle wins.
   always_ff @(posedge clk) begin
      if (!reset) arb_lost <= 1'b0;
      else        arb_lost <= arb_set | (arb_lost & ~arb_clr);
   end
endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// Directed bench: the stimulus queues expected output snapshots keyed by
// cycle number; a negedge monitor pops and compares them.
module tb_i2c_pad_conditioner;
   logic clk = 1'b0;
   logic reset, scl_pad_raw, sda_pad_raw, scl_padoen, sda_padoen, arb_check, arb_clr;
   logic scl_i, sda_i, start_det, stop_det, bus_busy, scl_stretch, arb_lost;

   // Output snapshot bit positions: {scl_i, sda_i, start, stop, busy, stretch, arb}
   localparam logic [6:0] M_SCL = 7'b1000000;
   localparam logic [6:0] M_SDA = 7'b0100000;
   localparam logic [6:0] M_STA = 7'b0010000;
   localparam logic [6:0] M_STO = 7'b0001000;
   localparam logic [6:0] M_BSY = 7'b0000100;
   localparam logic [6:0] M_STR = 7'b0000010;
   localparam logic [6:0] M_ARB = 7'b0000001;
   localparam logic [6:0] M_ALL = 7'b1111111;

   typedef struct {
      int         at;
      logic [6:0] mask;
      logic [6:0] val;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   i2c_pad_conditioner dut (
      .clk         (clk),
      .reset       (reset),
      .scl_pad_raw (scl_pad_raw),
      .sda_pad_raw (sda_pad_raw),
      .scl_padoen  (scl_padoen),
      .sda_padoen  (sda_padoen),
      .arb_check   (arb_check),
      .arb_clr     (arb_clr),
      .scl_i       (scl_i),
      .sda_i       (sda_i),
      .start_det   (start_det),
      .stop_det    (stop_det),
      .bus_busy    (bus_busy),
      .scl_stretch (scl_stretch),
      .arb_lost    (arb_lost)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_at(input int at, input logic [6:0] m, input logic [6:0] v, input string nm);
      exp_t e;
      e.at = at; e.mask = m; e.val = v; e.nm = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every entry due this cycle; at the end, anything left
   // over was never reached and counts as an error.
   always @(negedge clk) begin
      logic [6:0] obs;
      obs = {scl_i, sda_i, start_det, stop_det, bus_busy, scl_stretch, arb_lost};
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].at == cyc) begin
            checks++;
            if ((obs & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
               errors++;
               $display("FAIL %s @cyc %0d: got %b want %b (mask %b)", exp_q[i].nm, cyc,
                        obs & exp_q[i].mask, exp_q[i].val & exp_q[i].mask, exp_q[i].mask);
            end
            exp_q.delete(i);
         end
      end
      if (done) begin
         foreach (exp_q[i]) begin
            errors++;
            $display("FAIL %s unchecked: due cyc %0d, now %0d", exp_q[i].nm, exp_q[i].at, cyc);
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: stimulus did not complete, cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      reset = 1'b0; scl_pad_raw = 1'b1; sda_pad_raw = 1'b1;
      scl_padoen = 1'b1; sda_padoen = 1'b1; arb_check = 1'b0; arb_clr = 1'b0;
      tick(3);
      exp_at(cyc, M_ALL, 7'b1100000, "reset_state");
      reset = 1'b1;
      tick(5);

      // 2-cycle SDA glitch must be swallowed
      t = cyc; sda_pad_raw = 1'b0; tick(2); sda_pad_raw = 1'b1;
      for (int k = 3; k <= 9; k++) exp_at(t + k, M_SDA | M_STA | M_BSY, 7'b0100000, "glitch");
      tick(10);

      // 3-cycle low with SCL high: filter latency, START then STOP
      t = cyc; sda_pad_raw = 1'b0; tick(3); sda_pad_raw = 1'b1;
      exp_at(t + 4,  M_SDA,                 7'b0100000, "flt_pre");
      exp_at(t + 5,  M_SDA | M_STA,         7'b0000000, "flt_fall");
      exp_at(t + 6,  M_SDA | M_STA | M_BSY, 7'b0010100, "start");
      exp_at(t + 7,  M_SDA | M_STA | M_BSY, 7'b0000100, "start_1cyc");
      exp_at(t + 8,  M_SDA | M_STO | M_BSY, 7'b0100100, "flt_rise");
      exp_at(t + 9,  M_STO | M_BSY,         7'b0001000, "stop");
      exp_at(t + 10, M_STO,                 7'b0000000, "stop_1cyc");
      tick(12);

      // Simultaneous SCL/SDA fall and rise while idle: no START/STOP
      t = cyc; scl_pad_raw = 1'b0; sda_pad_raw = 1'b0;
      exp_at(t + 5, M_SCL | M_SDA | M_STA | M_BSY, 7'b0000000, "both_fall");
      exp_at(t + 6, M_STA | M_BSY, 7'b0000000, "both_fall_nostart");
      exp_at(t + 7, M_STA | M_BSY, 7'b0000000, "both_fall_nostart2");
      tick(8);
      t = cyc; scl_pad_raw = 1'b1; sda_pad_raw = 1'b1;
      exp_at(t + 5, M_SCL | M_SDA | M_STO | M_BSY, 7'b1100000, "both_rise");
      exp_at(t + 6, M_STO | M_BSY, 7'b0000000, "both_rise_nostop");
      tick(8);

      // Busy, then SCL falls as SDA rises: not a STOP, bus stays busy
      t = cyc; sda_pad_raw = 1'b0;
      exp_at(t + 6, M_STA | M_BSY, 7'b0010100, "start2");
      tick(8);
      t = cyc; scl_pad_raw = 1'b0; sda_pad_raw = 1'b1;
      exp_at(t + 5, M_SCL | M_SDA, 7'b0100000, "cross");
      exp_at(t + 6, M_STA | M_STO | M_BSY, 7'b0000100, "cross_nostop");
      exp_at(t + 7, M_STA | M_STO | M_BSY, 7'b0000100, "cross_nostop2");
      tick(8);

      // Missed STOP: both lines high; busy drops after exactly 500 cycles
      t = cyc; scl_pad_raw = 1'b1;
      exp_at(t + 5,   M_SCL | M_SDA | M_BSY, 7'b1100100, "free_start");
      exp_at(t + 504, M_BSY,                 7'b0000100, "busfree_499");
      exp_at(t + 505, M_BSY | M_STO,         7'b0000000, "busfree_500");
      tick(510);

      // Arbitration lost: SDA held low externally while SCL rises
      t = cyc; sda_pad_raw = 1'b0;
      exp_at(t + 6, M_STA | M_BSY, 7'b0010100, "start3");
      tick(8);
      scl_pad_raw = 1'b0; tick(8);
      arb_check = 1'b1;
      t = cyc; scl_pad_raw = 1'b1;
      exp_at(t + 5,  M_SCL | M_ARB, 7'b1000000, "arb_pre");
      exp_at(t + 6,  M_ARB,         7'b0000001, "arb_set");
      exp_at(t + 10, M_ARB | M_BSY, 7'b0000101, "arb_hold");
      tick(11);
      arb_check = 1'b0;
      t = cyc; arb_clr = 1'b1;
      exp_at(t + 1, M_ARB, 7'b0000000, "arb_clr");
      tick(1); arb_clr = 1'b0;

      // Set and clear in the same cycle: set wins
      scl_pad_raw = 1'b0; tick(8);
      arb_check = 1'b1;
      t = cyc; scl_pad_raw = 1'b1;
      tick(5); arb_clr = 1'b1;
      exp_at(t + 6, M_ARB, 7'b0000001, "arb_set_wins");
      exp_at(t + 7, M_ARB, 7'b0000001, "arb_set_hold");
      tick(1); arb_clr = 1'b0; arb_check = 1'b0;
      tick(3);

      // Flag survives a STOP
      t = cyc; sda_pad_raw = 1'b1;
      exp_at(t + 6, M_STO | M_BSY | M_ARB, 7'b0001001, "arb_thru_stop");
      tick(8);

      // Clock stretch while busy
      t = cyc; sda_pad_raw = 1'b0;
      exp_at(t + 6, M_BSY, 7'b0000100, "start4");
      tick(8);
      t = cyc; scl_pad_raw = 1'b0;
      exp_at(t + 5, M_SCL | M_STR, 7'b0000000, "str_pre");
      exp_at(t + 6, M_STR,         7'b0000010, "stretch");
      tick(8);
      t = cyc; scl_padoen = 1'b0;
      exp_at(t + 1, M_STR, 7'b0000000, "str_driven");
      tick(2);
      t = cyc; scl_padoen = 1'b1;
      exp_at(t + 1, M_STR, 7'b0000010, "str_again");
      tick(2);

      // Reset mid-transfer, then release with both lines low
      t = cyc; reset = 1'b0;
      exp_at(t,     M_ARB | M_BSY, 7'b0000101, "pre_reset");
      exp_at(t + 1, M_ALL,         7'b1100000, "mid_reset");
      tick(2);
      t = cyc; reset = 1'b1;
      for (int k = 1; k <= 8; k++) exp_at(t + k, M_STA | M_BSY, 7'b0000000, "post_reset_idle");
      exp_at(t + 8, M_SCL | M_SDA | M_STR, 7'b0000010, "post_reset_lines");
      tick(10);

      done = 1'b1;
   end
endmodule
